// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: mul/div op codes, forwarding selects, ALU op codes
// and small decode helpers for the mul/div unit.
package pipe_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  localparam logic [1:0] SRC_IMM = 2'd0;
  localparam logic [1:0] SRC_SA  = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_WB  = 2'd2;
  localparam logic [1:0] SRC_REG = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  function automatic logic md_is_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// Execute-stage ALU; shifts move operand b by the low bits of operand a.
module alu
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      aluc,
  output logic [XLEN-1:0] r,
  output logic            z
);

  // Operation decode
  always_comb begin
    case (aluc)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = b << a[SHW-1:0];
      ALU_SRL: r = b >> a[SHW-1:0];
      ALU_SRA: r = $unsigned($signed(b) >>> a[SHW-1:0]);
      default: r = a + b;
    endcase
  end

  assign z = (r == {XLEN{1'b0}});

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Works on magnitudes; the signed result is fixed up in the last iteration.
module md_unit
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} md_state_e;

  md_state_e         state_r;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   acc_r, mq_r, opnd_r, hi_r, lo_r;
  logic              is_div_r, neg_q_r, neg_r_r, div0_r;

  logic              sign_a_s, sign_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     sum_s, shifted_s, diff_s;
  logic [XLEN-1:0]   acc_nxt_s, mq_nxt_s, hi_fin_s, lo_fin_s;
  logic [2*XLEN-1:0] prod_s;

  assign sign_a_s = md_is_signed(op) & a[XLEN-1];
  assign sign_b_s = md_is_signed(op) & b[XLEN-1];
  assign mag_a_s  = sign_a_s ? -a : a;
  assign mag_b_s  = sign_b_s ? -b : b;

  // One iteration step plus the sign-corrected result used on the final step
  always_comb begin
    sum_s     = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    shifted_s = {acc_r, mq_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opnd_r};
    prod_s    = {(2*XLEN){1'b0}};
    if (is_div_r) begin
      if (diff_s[XLEN]) begin
        acc_nxt_s = shifted_s[XLEN-1:0];
        mq_nxt_s  = {mq_r[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt_s = diff_s[XLEN-1:0];
        mq_nxt_s  = {mq_r[XLEN-2:0], 1'b1};
      end
      hi_fin_s = neg_r_r ? -acc_nxt_s : acc_nxt_s;
      if (div0_r) begin
        lo_fin_s = {XLEN{1'b1}};
      end else if (neg_q_r) begin
        lo_fin_s = -mq_nxt_s;
      end else begin
        lo_fin_s = mq_nxt_s;
      end
    end else begin
      acc_nxt_s = sum_s[XLEN:1];
      mq_nxt_s  = {sum_s[0], mq_r[XLEN-1:1]};
      prod_s    = neg_q_r ? -{acc_nxt_s, mq_nxt_s} : {acc_nxt_s, mq_nxt_s};
      hi_fin_s  = prod_s[2*XLEN-1:XLEN];
      lo_fin_s  = prod_s[XLEN-1:0];
    end
  end

  // Control FSM, iteration registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      mq_r     <= {XLEN{1'b0}};
      opnd_r   <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && md_is_start(op)) begin
            state_r  <= ST_BUSY;
            cnt_r    <= CW'(XLEN);
            acc_r    <= {XLEN{1'b0}};
            mq_r     <= mag_a_s;
            opnd_r   <= mag_b_s;
            is_div_r <= (op == MD_DIV) || (op == MD_DIVU);
            neg_q_r  <= sign_a_s ^ sign_b_s;
            neg_r_r  <= sign_a_s;
            div0_r   <= (b == {XLEN{1'b0}});
          end else if (start && (op == MD_MTHI)) begin
            hi_r <= a;
          end else if (start && (op == MD_MTLO)) begin
            lo_r <= a;
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          mq_r  <= mq_nxt_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= ST_IDLE;
            hi_r    <= hi_fin_s;
            lo_r    <= lo_fin_s;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = (state_r == ST_BUSY);

endmodule

// File: rtl/mux32_4_1.sv
// Four-input operand mux, widened to any datapath width.
module mux32_4_1
  import pipe_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   s,
  output logic [W-1:0] y
);

  // Select one of the four forwarding sources
  always_comb begin
    case (s)
      SRC_IMM: y = d0;
      SRC_MEM: y = d1;
      SRC_WB:  y = d2;
      SRC_REG: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/exe_stage_md.sv
// Pipeline execute stage: operand forwarding, branch squash, ALU and the
// mul/div unit with its stall handshake towards the hazard unit.
module exe_stage_md
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btaken,
  input  logic            ewmem,
  input  logic            ewreg,
  input  logic            ebeq,
  input  logic            ebne,
  output logic            ewmem_1,
  output logic            ewreg_1,
  output logic            ebeq_1,
  output logic            ebne_1,
  input  logic [2:0]      ealuc,
  input  logic [1:0]      ealusrc_a,
  input  logic [1:0]      ealusrc_b,
  input  logic [1:0]      store_src,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] eimm,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] wbdata,
  input  logic            emd_en,
  input  logic [2:0]      emd_op,
  output logic [XLEN-1:0] ealu,
  output logic            z,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] alua,
  output logic [XLEN-1:0] alub,
  output logic            md_busy,
  output logic            stall
);

  logic [XLEN-1:0] sa_s, alu_r_s, hi_s, lo_s;
  logic            issue_s, kill_s;
  md_op_e          op_s;

  assign sa_s = {{(XLEN-SHW){1'b0}}, eimm[SHW+4:5]};
  assign op_s = md_op_e'(emd_op);

  mux32_4_1 #(.W(XLEN)) u_mux_a (.d0(sa_s), .d1(malu), .d2(wbdata), .d3(ea), .s(ealusrc_a), .y(alua));
  mux32_4_1 #(.W(XLEN)) u_mux_b (.d0(eimm), .d1(malu), .d2(wbdata), .d3(eb), .s(ealusrc_b), .y(alub));
  mux32_4_1 #(.W(XLEN)) u_mux_s (.d0(eb), .d1(malu), .d2(wbdata), .d3({XLEN{1'b0}}),
                                 .s(store_src), .y(store_data));

  alu #(.XLEN(XLEN), .SHW(SHW)) u_alu (.a(alua), .b(alub), .aluc(ealuc), .r(alu_r_s), .z(z));

  // Reset masks the stall so the front end is released while the unit clears
  assign stall   = emd_en & ~btaken & md_busy & ~rst;
  assign issue_s = emd_en & ~btaken & ~stall;
  assign kill_s  = btaken | stall;

  assign ewmem_1 = ewmem & ~kill_s;
  assign ewreg_1 = ewreg & ~kill_s;
  assign ebeq_1  = ebeq  & ~kill_s;
  assign ebne_1  = ebne  & ~kill_s;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk(clk), .rst(rst), .start(issue_s), .op(op_s),
    .a(alua), .b(alub), .hi(hi_s), .lo(lo_s), .busy(md_busy)
  );

  // Result select: MFHI/MFLO read HI/LO, everything else takes the ALU
  always_comb begin
    if (emd_en && (op_s == MD_MFHI)) begin
      ealu = hi_s;
    end else if (emd_en && (op_s == MD_MFLO)) begin
      ealu = lo_s;
    end else begin
      ealu = alu_r_s;
    end
  end

endmodule

// File: tb/tb_exe_stage_md.sv
// Self-checking bench for exe_stage_md: forwarding, squash, mul/div results,
// stall handshake, reset abort and a 64-bit instance.
module tb_exe_stage_md;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4, OP_MFLO = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, btaken, ewmem, ewreg, ebeq, ebne;
  logic [2:0]  ealuc, emd_op;
  logic [1:0]  ealusrc_a, ealusrc_b, store_src;
  logic [31:0] ea, eb, eimm, malu, wbdata;
  logic        emd_en;
  logic        ewmem_1, ewreg_1, ebeq_1, ebne_1, z, md_busy, stall;
  logic [31:0] ealu, store_data, alua, alub;

  logic [63:0] ea64, eb64, zero64;
  logic        emd_en64;
  logic [2:0]  emd_op64;
  logic        ewmem_1_64, ewreg_1_64, ebeq_1_64, ebne_1_64, z64, md_busy64, stall64;
  logic [63:0] ealu64, store_data64, alua64, alub64;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  exe_stage_md #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .btaken(btaken), .ewmem(ewmem), .ewreg(ewreg), .ebeq(ebeq), .ebne(ebne),
    .ewmem_1(ewmem_1), .ewreg_1(ewreg_1), .ebeq_1(ebeq_1), .ebne_1(ebne_1),
    .ealuc(ealuc), .ealusrc_a(ealusrc_a), .ealusrc_b(ealusrc_b), .store_src(store_src),
    .ea(ea), .eb(eb), .eimm(eimm), .malu(malu), .wbdata(wbdata),
    .emd_en(emd_en), .emd_op(emd_op), .ealu(ealu), .z(z), .store_data(store_data),
    .alua(alua), .alub(alub), .md_busy(md_busy), .stall(stall)
  );

  exe_stage_md #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .btaken(btaken), .ewmem(ewmem), .ewreg(ewreg), .ebeq(ebeq), .ebne(ebne),
    .ewmem_1(ewmem_1_64), .ewreg_1(ewreg_1_64), .ebeq_1(ebeq_1_64), .ebne_1(ebne_1_64),
    .ealuc(ealuc), .ealusrc_a(ealusrc_a), .ealusrc_b(ealusrc_b), .store_src(store_src),
    .ea(ea64), .eb(eb64), .eimm(zero64), .malu(zero64), .wbdata(zero64),
    .emd_en(emd_en64), .emd_op(emd_op64), .ealu(ealu64), .z(z64), .store_data(store_data64),
    .alua(alua64), .alub(alub64), .md_busy(md_busy64), .stall(stall64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    btaken = 1'b0; ewmem = 1'b0; ewreg = 1'b0; ebeq = 1'b0; ebne = 1'b0;
    ealuc = 3'd0; ealusrc_a = 2'd3; ealusrc_b = 2'd3; store_src = 2'd0;
    ea = 32'd0; eb = 32'd0; eimm = 32'd0; malu = 32'd0; wbdata = 32'd0;
    emd_en = 1'b0; emd_op = 3'd0;
    ea64 = 64'd0; eb64 = 64'd0; zero64 = 64'd0; emd_en64 = 1'b0; emd_op64 = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    emd_en = 1'b1; emd_op = OP_MFLO; exp_q.push_back(64'd0);
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
    n_chk++; if (md_busy64 !== 1'b0) begin n_fail++; $display("FAIL reset_busy64: got %b expected 0", md_busy64); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", ealu, e[31:0]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_forwarding_alu();
    logic [31:0] ea_t [4], eb_t [4], eb_x [4], sd_x [4], ex_t [8], a_t [8], b_t [8];
    logic [31:0] dbg;
    idle_inputs();
    eimm = 32'h0000_01A0; malu = 32'h1111_2222; wbdata = 32'h3333_4444;
    ea = 32'hAAAA_0001; eb = 32'hBBBB_0002;
    ea_t = '{32'd13, 32'h1111_2222, 32'h3333_4444, 32'hAAAA_0001};
    eb_x = '{32'h0000_01A0, 32'h1111_2222, 32'h3333_4444, 32'hBBBB_0002};
    sd_x = '{32'hBBBB_0002, 32'h1111_2222, 32'h3333_4444, 32'd0};
    for (int s = 0; s < 4; s++) begin
      ealusrc_a = 2'(s); ealusrc_b = 2'(s); store_src = 2'(s);
      @(negedge clk);
      n_chk++; if (alua !== ea_t[s]) begin n_fail++; $display("FAIL alua_sel%0d: got %h expected %h", s, alua, ea_t[s]); end
      n_chk++; if (alub !== eb_x[s]) begin n_fail++; $display("FAIL alub_sel%0d: got %h expected %h", s, alub, eb_x[s]); end
      n_chk++; if (store_data !== sd_x[s]) begin n_fail++; $display("FAIL store_sel%0d: got %h expected %h", s, store_data, sd_x[s]); end
      tick();
    end
    a_t  = '{32'd5, 32'd7, 32'hF0F0_F0F0, 32'hF0F0_0000, 32'hFFFF_0000, 32'd4, 32'd4, 32'd4};
    b_t  = '{32'd7, 32'd7, 32'hFF00_FF00, 32'h0000_0F0F, 32'h0F0F_0F0F, 32'd1, 32'h8000_0000, 32'h8000_0000};
    ex_t = '{32'd12, 32'd0, 32'hF000_F000, 32'hF0F0_0F0F, 32'hF0F0_0F0F, 32'd16, 32'h0800_0000, 32'hF800_0000};
    ealusrc_a = 2'd3; ealusrc_b = 2'd3;
    for (int i = 0; i < 8; i++) begin
      ealuc = 3'(i); ea = a_t[i]; eb = b_t[i];
      @(negedge clk);
      dbg = ealu;
      n_chk++; if (dbg !== ex_t[i]) begin n_fail++; $display("FAIL alu_op%0d: got %h expected %h", i, dbg, ex_t[i]); end
      n_chk++; if (z !== (ex_t[i] == 32'd0)) begin n_fail++; $display("FAIL alu_z%0d: got %b expected %b", i, z, ex_t[i] == 32'd0); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    idle_inputs();
    ewmem = 1'b1; ewreg = 1'b1; ebeq = 1'b1; ebne = 1'b1;
    @(negedge clk);
    n_chk++; if ({ewmem_1, ewreg_1, ebeq_1, ebne_1} !== 4'b1111) begin
      n_fail++; $display("FAIL squash_pass: got %b expected 1111", {ewmem_1, ewreg_1, ebeq_1, ebne_1}); end
    tick();
    btaken = 1'b1;
    @(negedge clk);
    n_chk++; if ({ewmem_1, ewreg_1, ebeq_1, ebne_1} !== 4'b0000) begin
      n_fail++; $display("FAIL squash_btaken: got %b expected 0000", {ewmem_1, ewreg_1, ebeq_1, ebne_1}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_md_ops();
    logic [2:0]  op_t [8];
    logic [31:0] a_t [8], b_t [8], hi_t [8], lo_t [8];
    op_t = '{OP_MULT, OP_DIVU, OP_DIV, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_MULT};
    a_t  = '{32'hFFFF_FFFD, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FF9C, 32'h8000_0000};
    b_t  = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'h8000_0000};
    hi_t = '{32'hFFFF_FFFF, 32'd100, 32'd0, 32'hFFFF_FFFE, 32'd1, 32'd1, 32'hFFFF_FF9C, 32'h4000_0000};
    lo_t = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      emd_en = 1'b1; emd_op = op_t[i]; ea = a_t[i]; eb = b_t[i];
      @(negedge clk);
      n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL md%0d_issue_stall: got %b expected 0", i, stall); end
      tick();
      emd_en = 1'b0;
      for (int k = 1; k <= 32; k++) begin
        @(negedge clk);
        n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md%0d_busy_c%0d: got %b expected 1", i, k, md_busy); end
        tick();
      end
      emd_en = 1'b1; emd_op = OP_MFLO; exp_q.push_back({32'd0, lo_t[i]});
      @(negedge clk);
      n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md%0d_done: got %b expected 0", i, md_busy); end
      e = exp_q.pop_front();
      n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL md%0d_lo: got %h expected %h", i, ealu, e[31:0]); end
      tick();
      emd_op = OP_MFHI; exp_q.push_back({32'd0, hi_t[i]});
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL md%0d_hi: got %h expected %h", i, ealu, e[31:0]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_div_stall();
    idle_inputs();
    emd_en = 1'b1; emd_op = OP_DIV; ea = 32'hFFFF_FFF9; eb = 32'd2;
    tick();
    emd_en = 1'b0;
    repeat (4) tick();
    emd_en = 1'b1; emd_op = OP_MFLO; ewreg = 1'b1; exp_q.push_back(64'h0000_0000_FFFF_FFFD);
    for (int c = 5; c <= 32; c++) begin
      @(negedge clk);
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL divstall_c%0d: got %b expected 1", c, stall); end
      n_chk++; if (ewreg_1 !== 1'b0) begin n_fail++; $display("FAIL divbubble_c%0d: got %b expected 0", c, ewreg_1); end
      tick();
    end
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL divstall_release: got %b expected 0", stall); end
    n_chk++; if (ewreg_1 !== 1'b1) begin n_fail++; $display("FAIL divstall_ewreg: got %b expected 1", ewreg_1); end
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL divstall_lo: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL divstall_hi: got %h expected %h", ealu, e[31:0]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_btaken_fwd();
    idle_inputs();
    btaken = 1'b1; ewreg = 1'b1; emd_en = 1'b1; emd_op = OP_MULT;
    ealusrc_a = 2'd1; malu = 32'd5; ealusrc_b = 2'd2; wbdata = 32'd6;
    @(negedge clk);
    n_chk++; if (ewreg_1 !== 1'b0) begin n_fail++; $display("FAIL bt_ewreg: got %b expected 0", ewreg_1); end
    n_chk++; if (alua !== 32'd5) begin n_fail++; $display("FAIL bt_alua: got %h expected 5", alua); end
    n_chk++; if (alub !== 32'd6) begin n_fail++; $display("FAIL bt_alub: got %h expected 6", alub); end
    tick();
    btaken = 1'b0; ewreg = 1'b0; emd_op = OP_MFLO; exp_q.push_back(64'h0000_0000_FFFF_FFFD);
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL bt_nostart: got %b expected 0", md_busy); end
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL bt_lo_kept: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MULT;
    tick();
    emd_en = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL fwdmul_busy_c%0d: got %b expected 1", k, md_busy); end
      tick();
    end
    emd_en = 1'b1; emd_op = OP_MFLO; exp_q.push_back(64'd30);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL fwdmul_lo: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL fwdmul_hi: got %h expected %h", ealu, e[31:0]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_mt();
    idle_inputs();
    emd_en = 1'b1; emd_op = OP_MULTU; ea = 32'd3; eb = 32'd4;
    tick();
    emd_en = 1'b0;
    repeat (9) tick();
    rst = 1'b1; emd_en = 1'b1; emd_op = OP_MFLO;
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", md_busy); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
    tick();
    rst = 1'b0; exp_q.push_back(64'd0);
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b expected 0", md_busy); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall_after: got %b expected 0", stall); end
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL rstmid_lo: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL rstmid_hi: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MTHI; ea = 32'h0000_1234;
    tick();
    emd_op = OP_MTLO; ea = 32'h0000_ABCD;
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'h1234);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL mthi: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFLO; exp_q.push_back(64'hABCD);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL mtlo: got %h expected %h", ealu, e[31:0]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    emd_en = 1'b1; emd_op = OP_MULTU; ea = 32'h0001_0000; eb = 32'h0001_0000;
    tick();
    emd_en = 1'b0;
    repeat (32) tick();
    emd_en = 1'b1; emd_op = OP_MULT; ea = 32'd6; eb = 32'hFFFF_FFFE;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b expected 0", stall); end
    tick();
    emd_en = 1'b0;
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b expected 1", md_busy); end
    repeat (32) tick();
    emd_en = 1'b1; emd_op = OP_MFLO; exp_q.push_back(64'h0000_0000_FFFF_FFF4);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL b2b_lo: got %h expected %h", ealu, e[31:0]); end
    tick();
    emd_op = OP_MFHI; exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if ({32'd0, ealu} !== e) begin n_fail++; $display("FAIL b2b_hi: got %h expected %h", ealu, e[31:0]); end
    tick();
    idle_inputs();
  endtask

  task automatic test_xlen64();
    idle_inputs();
    emd_en64 = 1'b1; emd_op64 = OP_MULTU; ea64 = 64'hFFFF_FFFF_FFFF_FFFF; eb64 = 64'd2;
    tick();
    emd_en64 = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n_chk++; if (md_busy64 !== 1'b1) begin n_fail++; $display("FAIL x64_busy_c%0d: got %b expected 1", k, md_busy64); end
      tick();
    end
    emd_en64 = 1'b1; emd_op64 = OP_MFLO; exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    n_chk++; if (md_busy64 !== 1'b0) begin n_fail++; $display("FAIL x64_done: got %b expected 0", md_busy64); end
    e = exp_q.pop_front();
    n_chk++; if (ealu64 !== e) begin n_fail++; $display("FAIL x64_lo: got %h expected %h", ealu64, e); end
    tick();
    emd_op64 = OP_MFHI; exp_q.push_back(64'd1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++; if (ealu64 !== e) begin n_fail++; $display("FAIL x64_hi: got %h expected %h", ealu64, e); end
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forwarding_alu();
    test_squash();
    test_md_ops();
    test_div_stall();
    test_btaken_fwd();
    test_reset_mid_mt();
    test_back_to_back();
    test_xlen64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage_md.md
Name: exe_stage_md

Overview:
- Parametrised successor of the pipeline execute stage: ALU operand forwarding muxes, store-data forwarding and branch squash of control bits.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- Adds a stall handshake to the hazard unit so the 5-stage pipeline supports MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO at any data width.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- btaken  in  1  branch taken; squashes the EX instruction.
- ewmem, ewreg, ebeq, ebne  in  1 each  EX control bits.
- ewmem_1, ewreg_1, ebeq_1, ebne_1  out  1 each  squashed/bubbled control bits to MEM.
- ealuc  in  3  ALU op.
- ealusrc_a, ealusrc_b, store_src  in  2 each  forwarding selects.
- ea, eb, eimm, malu, wbdata  in  XLEN each  register operands, immediate, MEM forward, WB forward.
- emd_en  in  1  EX instruction is a mul/div-class op.
- emd_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- ealu  out  XLEN  EX result.
- z  out  1  ALU zero flag.
- store_data, alua, alub  out  XLEN each  forwarded store data and ALU operands.
- md_busy  out  1  iteration in progress.
- stall  out  1  freeze IF/ID/EX registers.

Behaviour:
- Operand muxes:
  - alua select 0/1/2/3 = sa, malu, wbdata, ea; sa = zero-extended eimm[SHW+4:5].
  - alub select 0/1/2/3 = eimm, malu, wbdata, eb.
  - store_data select 0/1/2/3 = eb, malu, wbdata, 0.
- Squash: each *_1 output = input & ~btaken & ~stall, so a stalled EX sends a bubble to MEM.
- ealu: HI for MFHI and LO for MFLO when emd_en; ALU result otherwise. z always comes from the ALU.
- issue = emd_en & ~btaken & ~stall.
- stall = emd_en & ~btaken & md_busy, for any emd_op. This covers a new MULT/DIV, an MFxx or an MTxx while busy.
- FSM IDLE -> BUSY -> IDLE.
  - IDLE: issue of op 0–3 at cycle T captures alua/alub into operand registers and the counter is set to XLEN.
  - BUSY: md_busy=1 for cycles T+1..T+XLEN, counter decrements each cycle.
  - On the count 1->0 edge (end of cycle T+XLEN), HI/LO are written and the FSM returns to IDLE.
  - MFHI/MFLO issued in cycle T+XLEN+1 read the new values. Back-to-back start is allowed from T+XLEN+1.
- Arithmetic:
  - Radix-2 shift-add multiply and restoring divide on unsigned magnitudes.
  - Signed ops negate operands with MSB set; the result sign is fixed in the final cycle.
  - Product {HI,LO} is 2*XLEN bits.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Most-negative / -1: LO = 0x8000_0000 (XLEN=32), HI = 0.
  - Divide by zero: LO = all ones, HI = dividend. No trap.
- MTHI/MTLO when idle: HI or LO <= alua at the end of the issue cycle. An MFxx in the next cycle sees the new value.
- btaken on an issue-candidate cycle: no start, no HI/LO write.
- btaken while BUSY: the in-flight operation continues. It was issued earlier and is not squashable.
- rst: IDLE, counter 0, HI = LO = 0, md_busy = 0. Reset mid-operation aborts it with no HI/LO write. stall = 0 in the reset cycle and the cycle after.
- Combinational paths: ealu, alua, alub, store_data, *_1, stall. Registered: HI, LO, operands, counter, state.

Decomposition:
- Shared package pipe_pkg holds:
  - md_op_e enum (8 codes above).
  - Forwarding-select constants SRC_IMM/SA = 0, SRC_MEM = 1, SRC_WB = 2, SRC_REG = 3.
  - XLEN default.
- One sub-module, md_unit: FSM, counter, HI/LO, signed fix-up. Ports start, op, a, b, hi, lo, busy.
- Reuse the existing alu and mux32_4_1, widened to XLEN via a parameter.

Test Plan:
- MULT with alua = -3 (0xFFFF_FFFD), alub = 7, issued at T -> md_busy high T+1..T+32; MFLO at T+33 gives ealu = 0xFFFF_FFEB; MFHI gives 0xFFFF_FFFF.
- DIV -7 / 2 at T, then MFLO issued at T+5 -> stall=1 and ewreg_1=0 for T+5..T+32; at T+33 ealu = 0xFFFF_FFFD (LO = -3); MFHI gives 0xFFFF_FFFF (HI = -1).
- DIVU 100 / 0 -> LO = 0xFFFF_FFFF, HI = 100. DIV 0x8000_0000 / -1 -> LO = 0x8000_0000, HI = 0.
- MULT issued with btaken=1 -> md_busy stays 0, HI/LO unchanged; ewreg=1 gives ewreg_1=0. Same op with btaken=0 and alusrc_a=1 (malu = 5), alusrc_b=2 (wbdata = 6) -> LO = 30.
- rst asserted at T+10 of a MULTU -> next cycle md_busy=0, HI=LO=0; MFLO gives ealu = 0. MTHI 0x1234 then MFHI next cycle gives 0x1234.
- XLEN=64: MULTU 0xFFFF_FFFF_FFFF_FFFF x 2 -> HI = 1, LO = 0xFFFF_FFFF_FFFF_FFFE, md_busy for 64 cycles.
